// File: rtl/dc_pkg.sv
// Shared helpers for the dual-clock buffer controllers.
// Gray/binary conversion is done on a fixed-width word; callers cast.
package dc_pkg;

    localparam int GW = 32;

    typedef logic [GW-1:0] gword_t;

    function automatic gword_t bin2gray(input gword_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic gword_t gray2bin(input gword_t g);
        gword_t b;
        b[GW-1] = g[GW-1];
        for (int i = GW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/dc_sync_flops.sv
// N-stage flop chain for bringing a Gray pointer into the local clock domain.
module dc_sync_flops #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/dc_write_ctrl.sv
// Write-side controller of a dual-clock buffer: one-hot slot pointer,
// Gray write count out, synchronized read count in, conservative full.
module dc_write_ctrl
    import dc_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 8,
    parameter int SYNC_STAGES  = 2,
    localparam int AW          = $clog2(BUFFER_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    valid_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic                    ready_o,
    output logic [BUFFER_DEPTH-1:0] write_pointer,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic [AW:0]             wr_ptr_gray_o,
    input  logic [AW:0]             rd_ptr_gray_async_i,
    output logic [AW:0]             count_o
);

    localparam int CW = AW + 1;

    logic [AW:0] wcnt;
    logic [AW:0] wcnt_nxt;
    logic [AW:0] rd_sync;
    logic [AW:0] rcnt_s;
    logic        full;
    logic        push;

    dc_sync_flops #(
        .WIDTH  (CW),
        .STAGES (SYNC_STAGES)
    ) u_rd_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (rd_ptr_gray_async_i),
        .q    (rd_sync)
    );

    // Occupancy and full come only from flops, so ready never sees valid_i.
    assign rcnt_s     = CW'(gray2bin(GW'(rd_sync)));
    assign count_o    = wcnt - rcnt_s;
    assign full       = (count_o == CW'(BUFFER_DEPTH));
    assign ready_o    = !full;
    assign push       = valid_i && ready_o;
    assign wcnt_nxt   = wcnt + CW'(1);
    assign write_data = data_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wcnt          <= '0;
            write_pointer <= BUFFER_DEPTH'(1);
            wr_ptr_gray_o <= '0;
        end else if (push) begin
            wcnt          <= wcnt_nxt;
            write_pointer <= {write_pointer[BUFFER_DEPTH-2:0],
                              write_pointer[BUFFER_DEPTH-1]};
            wr_ptr_gray_o <= CW'(bin2gray(GW'(wcnt_nxt)));
        end
    end

endmodule

// File: tb/tb_dc_write_ctrl.sv
// Directed bench for dc_write_ctrl (depth 8, two sync stages).
module tb_dc_write_ctrl;

    localparam int DW = 32;
    localparam int BD = 8;
    localparam int SS = 2;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          ready_o;
    logic [BD-1:0] write_pointer;
    logic [DW-1:0] write_data;
    logic [AW:0]   wr_ptr_gray_o;
    logic [AW:0]   rd_ptr_gray_async_i;
    logic [AW:0]   count_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dc_write_ctrl #(
        .DATA_WIDTH   (DW),
        .BUFFER_DEPTH (BD),
        .SYNC_STAGES  (SS)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .valid_i             (valid_i),
        .data_i              (data_i),
        .ready_o             (ready_o),
        .write_pointer       (write_pointer),
        .write_data          (write_data),
        .wr_ptr_gray_o       (wr_ptr_gray_o),
        .rd_ptr_gray_async_i (rd_ptr_gray_async_i),
        .count_o             (count_o)
    );

    typedef struct {
        logic          v;
        logic [AW:0]   rd;
        logic [BD-1:0] wp;
        logic [AW:0]   g;
        logic          rdy;
        logic [AW:0]   cnt;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn                = 1'b0;
        valid_i             = 1'b0;
        data_i              = '0;
        rd_ptr_gray_async_i = '0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_wp"},    32'(write_pointer), 32'h01);
        chk({tag, "_gray"},  32'(wr_ptr_gray_o), 32'h0);
        chk({tag, "_ready"}, 32'(ready_o),       32'h1);
        chk({tag, "_count"}, 32'(count_o),       32'h0);
    endtask

    function automatic logic [AW:0] g4(input int b);
        logic [AW:0] x;
        x = 4'(b);
        return x ^ (x >> 1);
    endfunction

    initial begin
        tbl[0]  = '{1'b1, 4'h0, 8'h02, 4'b0001, 1'b1, 4'd1};
        tbl[1]  = '{1'b1, 4'h0, 8'h04, 4'b0011, 1'b1, 4'd2};
        tbl[2]  = '{1'b1, 4'h0, 8'h08, 4'b0010, 1'b1, 4'd3};
        tbl[3]  = '{1'b1, 4'h0, 8'h10, 4'b0110, 1'b1, 4'd4};
        tbl[4]  = '{1'b1, 4'h0, 8'h20, 4'b0111, 1'b1, 4'd5};
        tbl[5]  = '{1'b1, 4'h0, 8'h40, 4'b0101, 1'b1, 4'd6};
        tbl[6]  = '{1'b1, 4'h0, 8'h80, 4'b0100, 1'b1, 4'd7};
        tbl[7]  = '{1'b1, 4'h0, 8'h01, 4'b1100, 1'b0, 4'd8};
        for (int i = 8; i < 13; i++) begin
            tbl[i] = '{1'b1, 4'h0, 8'h01, 4'b1100, 1'b0, 4'd8};
        end
        tbl[13] = '{1'b0, 4'b0001, 8'h01, 4'b1100, 1'b0, 4'd8};
        tbl[14] = '{1'b0, 4'b0001, 8'h01, 4'b1100, 1'b1, 4'd7};
        tbl[15] = '{1'b0, 4'b0001, 8'h01, 4'b1100, 1'b1, 4'd7};
        tbl[16] = '{1'b1, 4'b0001, 8'h02, 4'b1101, 1'b0, 4'd8};

        // Reset release, then fill / hold-full / drain-one table.
        do_reset();
        chk_reset_state("rst_release");
        for (int i = 0; i < 17; i++) begin
            valid_i             = tbl[i].v;
            rd_ptr_gray_async_i = tbl[i].rd;
            data_i              = $urandom;
            #1;
            chk($sformatf("v%0d_wdata", i), write_data, data_i);
            step();
            chk($sformatf("v%0d_wp", i),    32'(write_pointer), 32'(tbl[i].wp));
            chk($sformatf("v%0d_gray", i),  32'(wr_ptr_gray_o), 32'(tbl[i].g));
            chk($sformatf("v%0d_ready", i), 32'(ready_o),       32'(tbl[i].rdy));
            chk($sformatf("v%0d_count", i), 32'(count_o),       32'(tbl[i].cnt));
        end

        // Streaming with the read side following: wraps the count twice.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            logic [AW:0]   prev_g;
            logic [AW:0]   exp_cnt;
            logic [BD-1:0] exp_wp;
            logic [AW:0]   diff;
            prev_g              = wr_ptr_gray_o;
            valid_i             = 1'b1;
            rd_ptr_gray_async_i = g4(k);
            data_i              = $urandom;
            step();
            exp_cnt = 4'(k + 1) - ((k >= 1) ? 4'(k - 1) : 4'd0);
            exp_wp  = 8'(1) << ((k + 1) % 8);
            diff    = prev_g ^ wr_ptr_gray_o;
            chk($sformatf("s%0d_gray", k),  32'(wr_ptr_gray_o), 32'(g4(k + 1)));
            chk($sformatf("s%0d_1bit", k),  32'($countones(diff)), 32'd1);
            chk($sformatf("s%0d_wp", k),    32'(write_pointer), 32'(exp_wp));
            chk($sformatf("s%0d_ready", k), 32'(ready_o),       32'h1);
            chk($sformatf("s%0d_count", k), 32'(count_o),       32'(exp_cnt));
        end

        // Reset pulsed mid-stream at count 5.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            valid_i = 1'b1;
            data_i  = $urandom;
            step();
        end
        chk("mid_count5", 32'(count_o), 32'd5);
        chk("mid_wp5", 32'(write_pointer), 32'h20);
        #2 rstn = 1'b0;
        #1;
        chk_reset_state("mid_async");
        step();
        chk_reset_state("mid_held");
        rstn    = 1'b1;
        valid_i = 1'b0;
        step();
        chk_reset_state("mid_release");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dc_write_ctrl.md
DC_WRITE_CTRL -- requirements
Module: dc_write_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, payload width.
REQ-002 Parameter BUFFER_DEPTH, default 8, number of buffer slots; a power of two and at least 2.
REQ-003 Parameter SYNC_STAGES, default 2, number of synchronizer flops on the read-pointer crossing; at least 2.
REQ-004 Let AW = $clog2(BUFFER_DEPTH).
REQ-005 Port clk, input, 1 bit, write-domain clock.
REQ-006 Port rstn, input, 1 bit, reset: asynchronous, active-low.
REQ-007 Port valid_i, input, 1 bit, producer has data.
REQ-008 Port data_i, input, DATA_WIDTH bits, producer payload.
REQ-009 Port ready_o, output, 1 bit, slot free; a transfer occurs on valid_i && ready_o.
REQ-010 Port write_pointer, output, BUFFER_DEPTH bits, one-hot slot index to the data buffer.
REQ-011 Port write_data, output, DATA_WIDTH bits, data to the data buffer.
REQ-012 Port wr_ptr_gray_o, output, AW+1 bits, Gray-coded write count for the read domain.
REQ-013 Port rd_ptr_gray_async_i, input, AW+1 bits, Gray-coded read count from the read domain, asynchronous to clk.
REQ-014 Port count_o, output, AW+1 bits, conservative occupancy seen from the write side.

Function
REQ-015 The block SHALL keep a binary write count wcnt of AW+1 bits; wcnt[AW] is the wrap bit.
REQ-016 write_pointer SHALL be a registered one-hot decode of wcnt[AW-1:0], exactly one bit set at all times.
REQ-017 write_data SHALL equal data_i combinationally.
REQ-018 The buffer writes its current slot every cycle, so the slot at write_pointer SHALL be treated as scratch until the pointer advances.
REQ-019 On a transfer, the block SHALL increment wcnt and rotate write_pointer left by one (bit BUFFER_DEPTH-1 wraps to bit 0) at the same clk edge.
REQ-020 wr_ptr_gray_o SHALL be registered and equal bin2gray(wcnt), changing at most 1 bit per cycle.
REQ-021 rd_ptr_gray_async_i SHALL pass through SYNC_STAGES flops before use; the synchronized value is gray2bin-converted to rcnt_s.
REQ-022 count_o SHALL equal (wcnt - rcnt_s) mod 2^(AW+1), computed from flops only.
REQ-023 Full SHALL be count_o == BUFFER_DEPTH, i.e. equal low bits and differing wrap bit; ready_o SHALL be !full.
REQ-024 ready_o SHALL NOT depend combinationally on valid_i.
REQ-025 When full, valid_i SHALL be ignored: wcnt, write_pointer and wr_ptr_gray_o are held.
REQ-026 Latency: after the transfer that fills the last slot, ready_o SHALL deassert in the next cycle.
REQ-027 After a read-side pointer change, ready_o SHALL reassert SYNC_STAGES cycles later, never earlier.
REQ-028 Simultaneous transfer and read-pointer update in one cycle SHALL both be reflected in count_o in the next cycle.
REQ-029 Wrap-around: wcnt rolls over from 2^(AW+1)-1 to 0 with no loss of full or empty correctness.
REQ-030 Capacity SHALL be exactly BUFFER_DEPTH entries.

Reset
REQ-031 While rstn is low: wcnt = 0, write_pointer = one-hot bit 0, wr_ptr_gray_o = 0, all synchronizer flops = 0, count_o = 0, ready_o = 1.
REQ-032 Reset asserted mid-transfer SHALL discard the in-flight transfer and return to the REQ-031 state immediately.
REQ-033 The read side is reset in the same reset event, so no cross-domain recovery logic is required.

Structure
REQ-034 bin2gray and gray2bin functions SHALL live in the shared package dc_pkg and be reused by the read-side controller.
REQ-035 The N-stage synchronizer SHALL be a sub-module dc_sync_flops (parameters WIDTH and STAGES, with async reset), instantiated once.
REQ-036 No other sub-modules; estimated RTL size 120-200 lines.

Verification (BUFFER_DEPTH=8, SYNC_STAGES=2)
REQ-037 Reset release with valid_i=0 -> write_pointer=8'h01, wr_ptr_gray_o=0, ready_o=1, count_o=0.
REQ-038 8 back-to-back transfers with rd ptr=0 -> write_pointer walks 01..80, ready_o=0 in the cycle after the 8th, count_o=8, write_pointer back at 8'h01.
REQ-039 Full, then rd_ptr_gray_async_i set to gray(1)=4'b0001 -> ready_o=1 exactly 2 cycles later, count_o=7.
REQ-040 Stream 40 transfers with the read side draining at the same rate -> wcnt wraps past 15, wr_ptr_gray_o changes 1 bit per step, no spurious full.
REQ-041 valid_i held high while full for 5 cycles -> write_pointer and wr_ptr_gray_o stable, count_o stays 8.
REQ-042 rstn pulsed low mid-stream at count 5 -> all outputs match REQ-031 within the same cycle, no X values.
